// File: rtl/vga_timing_gen.sv
// SVGA 800x600@72Hz raster generator: scan position to the renderer, blanked and
// sync-aligned RGB565 plus hsync/vsync to the pins.
module vga_timing_gen #(
  parameter int   H_ACTIVE  = 800,
  parameter int   H_FP      = 56,
  parameter int   H_SYNC    = 120,
  parameter int   H_BP      = 64,
  parameter int   V_ACTIVE  = 600,
  parameter int   V_FP      = 37,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 23,
  parameter logic HS_POL    = 1'b1,
  parameter logic VS_POL    = 1'b1,
  parameter int   COLOR_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] red,
  input  logic [5:0] green,
  input  logic [4:0] blue,
  output logic [9:0] row,
  output logic [9:0] column,
  output logic       frame_start,
  output logic [4:0] vga_r,
  output logic [5:0] vga_g,
  output logic [4:0] vga_b,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  column_q, column_d;
  logic        frame_start_q, frame_start_d;

  logic [COLOR_LAT-1:0] vis_pipe_q, vis_pipe_d;
  logic [COLOR_LAT-1:0] hs_pipe_q, hs_pipe_d;
  logic [COLOR_LAT-1:0] vs_pipe_q, vs_pipe_d;

  logic [4:0] vga_r_q, vga_r_d;
  logic [5:0] vga_g_q, vga_g_d;
  logic [4:0] vga_b_q, vga_b_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;

  logic vis_raw, hs_raw, vs_raw;
  logic vis_dly;

  always_comb begin
    h_cnt_d = h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end
    // Column and frame_start are registered from the next count so they line up
    // with row (= v_cnt_q) in the same cycle.
    column_d      = (h_cnt_d < H_ACT) ? h_cnt_d[9:0] : 10'h3FF;
    frame_start_d = (h_cnt_d == '0) && (v_cnt_d == '0);
  end

  always_comb begin
    vis_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    hs_raw  = (h_cnt_q >= HS_START) && (h_cnt_q <= HS_END);
    vs_raw  = (v_cnt_q >= VS_START) && (v_cnt_q <= VS_END);

    vis_pipe_d    = vis_pipe_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    vis_pipe_d[0] = vis_raw;
    hs_pipe_d[0]  = hs_raw;
    vs_pipe_d[0]  = vs_raw;
    for (int i = 1; i < COLOR_LAT; i++) begin
      vis_pipe_d[i] = vis_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  // The delayed flags line up with the renderer's colour, so colour is gated here.
  always_comb begin
    vis_dly = vis_pipe_q[COLOR_LAT-1];
    vga_r_d = vis_dly ? red   : '0;
    vga_g_d = vis_dly ? green : '0;
    vga_b_d = vis_dly ? blue  : '0;
    hsync_d = hs_pipe_q[COLOR_LAT-1] ? HS_POL : ~HS_POL;
    vsync_d = vs_pipe_q[COLOR_LAT-1] ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      column_q      <= '0;
      frame_start_q <= 1'b1;
      vis_pipe_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      vga_r_q       <= '0;
      vga_g_q       <= '0;
      vga_b_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      column_q      <= column_d;
      frame_start_q <= frame_start_d;
      vis_pipe_q    <= vis_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      vga_r_q       <= vga_r_d;
      vga_g_q       <= vga_g_d;
      vga_b_q       <= vga_b_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign row         = v_cnt_q;
  assign column      = column_q;
  assign frame_start = frame_start_q;
  assign vga_r       = vga_r_q;
  assign vga_g       = vga_g_q;
  assign vga_b       = vga_b_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-raster instance so
// frame-level behaviour (vsync, frame period, mid-vsync reset) fits in a short run.
module tb_vga_timing_gen;

  localparam int D_HA = 800, D_HF = 56, D_HS = 120, D_HB = 64;
  localparam int D_VA = 600, D_VF = 37, D_VS = 6,   D_VB = 23, D_LAT = 1;
  localparam int S_HA = 20,  S_HF = 4,  S_HS = 6,   S_HB = 5;
  localparam int S_VA = 10,  S_VF = 3,  S_VS = 2,   S_VB = 2,  S_LAT = 3;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  logic       clk, rst_n;
  logic [4:0] d_red, s_red, d_r, s_r;
  logic [5:0] d_green, s_green, d_g, s_g;
  logic [4:0] d_blue, s_blue, d_b, s_b;
  logic [9:0] d_row, s_row, d_col, s_col;
  logic       d_fs, s_fs, d_hs, s_hs, d_vs, s_vs;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .red(d_red), .green(d_green), .blue(d_blue),
    .row(d_row), .column(d_col), .frame_start(d_fs),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .hsync(d_hs), .vsync(d_vs)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_LAT(S_LAT)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .red(s_red), .green(s_green), .blue(s_blue),
    .row(s_row), .column(s_col), .frame_start(s_fs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .hsync(s_hs), .vsync(s_vs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors, checks;
  int          k;
  int          mode;
  logic [31:0] seed;
  logic [15:0] q_d[$];
  logic [15:0] q_s[$];
  logic [38:0] obs_d, obs_s, exp_v;

  assign obs_d = {d_row, d_col, d_fs, d_r, d_g, d_b, d_hs, d_vs};
  assign obs_s = {s_row, s_col, s_fs, s_r, s_g, s_b, s_hs, s_vs};

  // Colour the renderer assigns to a visible pixel.
  function automatic logic [15:0] pattern(int md, int c, int r, logic [31:0] sd);
    logic [31:0] h;
    h = 32'(c) * 32'd2654435761 + 32'(r) * 32'd40503 + sd;
    case (md)
      0:       return h[15:0] ^ h[31:16];
      1:       return (c == 5 && r == 3) ? 16'hF800 : 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Renderer: garbage outside the visible area (all-ones in mode 2).
  function automatic logic [15:0] render(logic [9:0] r, logic [9:0] c, int va);
    if (c != 10'd1023 && int'(r) < va) return pattern(mode, int'(c), int'(r), seed);
    return (mode == 2) ? 16'hFFFF : 16'($urandom);
  endfunction

  // Expected outputs kk cycles after reset release, from raster arithmetic.
  function automatic logic [38:0] model(int kk, int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb, int lat);
    int ht, vt, c, r, j, cj, rj;
    logic [9:0]  col;
    logic [15:0] px;
    logic        hsy, vsy, fs;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    c   = kk % ht;
    r   = (kk / ht) % vt;
    col = (c < ha) ? 10'(c) : 10'd1023;
    fs  = (c == 0) && (r == 0);
    px  = '0;
    hsy = 1'b0;
    vsy = 1'b0;
    j   = kk - lat - 1;
    if (j >= 0) begin
      cj  = j % ht;
      rj  = (j / ht) % vt;
      if (cj < ha && rj < va) px = pattern(mode, cj, rj, seed);
      hsy = (cj >= ha + hf) && (cj < ha + hf + hs);
      vsy = (rj >= va + vf) && (rj < va + vf + vs);
    end
    return {10'(r), col, fs, px, hsy, vsy};
  endfunction

  task automatic step();
    logic        was_rst;
    logic [15:0] v;
    was_rst = !rst_n;
    @(posedge clk);
    #1;
    k = was_rst ? 0 : k + 1;
    v = q_d.pop_front();
    {d_red, d_green, d_blue} = v;
    q_d.push_back(render(d_row, d_col, D_VA));
    v = q_s.pop_front();
    {s_red, s_green, s_blue} = v;
    q_s.push_back(render(s_row, s_col, S_VA));
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    mode = 0;
    seed = $urandom;
    do_reset(3);
    checks += 7;
    if (d_row !== 10'd0) begin errors++; $display("FAIL reset_row got=%0d exp=0", d_row); end
    if (d_col !== 10'd0) begin errors++; $display("FAIL reset_col got=%0d exp=0", d_col); end
    if (d_fs !== 1'b1) begin errors++; $display("FAIL reset_fs got=%b exp=1", d_fs); end
    if ({d_r, d_g, d_b} !== 16'h0) begin
      errors++; $display("FAIL reset_rgb got=%h exp=0000", {d_r, d_g, d_b});
    end
    if (d_hs !== 1'b0) begin errors++; $display("FAIL reset_hsync got=%b exp=0", d_hs); end
    if (d_vs !== 1'b0) begin errors++; $display("FAIL reset_vsync got=%b exp=0", d_vs); end
    exp_v = model(0, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
    if (obs_s !== exp_v) begin errors++; $display("FAIL reset_small got=%h exp=%h", obs_s, exp_v); end
  endtask

  task automatic test_free_run();
    int last_fs, n_fs;
    mode = 0;
    seed = $urandom;
    do_reset(2);
    last_fs = 0;
    n_fs = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      exp_v = model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_LAT);
      checks++;
      if (obs_d !== exp_v) begin errors++; $display("FAIL free_run_d k=%0d got=%h exp=%h", k, obs_d, exp_v); end
      exp_v = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
      checks++;
      if (obs_s !== exp_v) begin errors++; $display("FAIL free_run_s k=%0d got=%h exp=%h", k, obs_s, exp_v); end
      if (s_fs) begin
        n_fs++;
        checks++;
        if (k - last_fs != S_HT * S_VT) begin
          errors++; $display("FAIL frame_period got=%0d exp=%0d", k - last_fs, S_HT * S_VT);
        end
        last_fs = k;
      end
    end
    checks++;
    if (n_fs != 2000 / (S_HT * S_VT)) begin
      errors++; $display("FAIL frame_count got=%0d exp=%0d", n_fs, 2000 / (S_HT * S_VT));
    end
  endtask

  task automatic test_line_sync();
    int rise_k, rises, width;
    logic prev;
    mode = 0;
    seed = $urandom;
    do_reset(1);
    rise_k = -1;
    rises = 0;
    width = 0;
    prev = d_hs;
    for (int i = 0; i < 2200; i++) begin
      step();
      exp_v = model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_LAT);
      checks++;
      if (obs_d !== exp_v) begin errors++; $display("FAIL line_sync_d k=%0d got=%h exp=%h", k, obs_d, exp_v); end
      if (d_hs && !prev) begin
        rises++;
        if (rise_k < 0) rise_k = k;
      end
      if (d_hs && k < 1040) width++;
      prev = d_hs;
    end
    checks += 3;
    if (rise_k != 858) begin errors++; $display("FAIL hsync_rise got=%0d exp=858", rise_k); end
    if (width != 120) begin errors++; $display("FAIL hsync_width got=%0d exp=120", width); end
    if (rises != 2) begin errors++; $display("FAIL hsync_rises got=%0d exp=2", rises); end
  endtask

  task automatic test_vsync();
    int rise_k, width;
    logic prev;
    mode = 0;
    seed = $urandom;
    do_reset(1);
    rise_k = -1;
    width = 0;
    prev = s_vs;
    for (int i = 0; i < S_HT * S_VT; i++) begin
      step();
      exp_v = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
      checks++;
      if (obs_s !== exp_v) begin errors++; $display("FAIL vsync_s k=%0d got=%h exp=%h", k, obs_s, exp_v); end
      if (s_vs && !prev && rise_k < 0) rise_k = k;
      if (s_vs) width++;
      prev = s_vs;
    end
    checks += 2;
    if (rise_k != (S_VA + S_VF) * S_HT + S_LAT + 1) begin
      errors++; $display("FAIL vsync_rise got=%0d exp=%0d", rise_k, (S_VA + S_VF) * S_HT + S_LAT + 1);
    end
    if (width != S_VS * S_HT) begin
      errors++; $display("FAIL vsync_width got=%0d exp=%0d", width, S_VS * S_HT);
    end
  endtask

  task automatic test_colour_path();
    int hits, hit_k;
    mode = 1;
    do_reset(1);
    hits = 0;
    hit_k = -1;
    for (int i = 0; i < 3 * 1040 + 200; i++) begin
      step();
      exp_v = model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_LAT);
      checks++;
      if (obs_d !== exp_v) begin errors++; $display("FAIL colour_d k=%0d got=%h exp=%h", k, obs_d, exp_v); end
      exp_v = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
      checks++;
      if (obs_s !== exp_v) begin errors++; $display("FAIL colour_s k=%0d got=%h exp=%h", k, obs_s, exp_v); end
      if (d_r == 5'h1F) begin hits++; hit_k = k; end
    end
    checks += 2;
    if (hits != 1) begin errors++; $display("FAIL colour_hits got=%0d exp=1", hits); end
    if (hit_k != 3 * 1040 + 5 + 2) begin errors++; $display("FAIL colour_time got=%0d exp=%0d", hit_k, 3 * 1040 + 7); end
  endtask

  task automatic test_blanking();
    mode = 2;
    do_reset(1);
    for (int i = 0; i < 2100; i++) begin
      step();
      exp_v = model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_LAT);
      checks++;
      if (obs_d !== exp_v) begin errors++; $display("FAIL blank_d k=%0d got=%h exp=%h", k, obs_d, exp_v); end
      exp_v = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
      checks++;
      if (obs_s !== exp_v) begin errors++; $display("FAIL blank_s k=%0d got=%h exp=%h", k, obs_s, exp_v); end
    end
  endtask

  // Reset taken in three places: mid-visible, mid-vsync, mid-hsync.
  task automatic test_reset_mid();
    int budget;
    mode = 0;
    seed = $urandom;
    for (int sc = 0; sc < 3; sc++) begin
      do_reset(1);
      budget = 0;
      while (!((sc == 0 && s_row == 10'd5 && s_col == 10'd12) ||
               (sc == 1 && s_vs && s_row == 10'(S_VA + S_VF + 1)) ||
               (sc == 2 && d_hs)) && budget < 2000) begin
        step();
        budget++;
      end
      checks++;
      if (budget >= 2000) begin errors++; $display("FAIL reset_mid_wait scenario=%0d got=timeout exp=reached", sc); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks += 4;
      if ({s_row, s_col} !== 20'h0) begin
        errors++; $display("FAIL reset_mid_pos scenario=%0d got=%h exp=00000", sc, {s_row, s_col});
      end
      if ({s_hs, s_vs} !== 2'b00) begin
        errors++; $display("FAIL reset_mid_sync_s scenario=%0d got=%b exp=00", sc, {s_hs, s_vs});
      end
      if ({d_row, d_col} !== 20'h0) begin
        errors++; $display("FAIL reset_mid_pos_d scenario=%0d got=%h exp=00000", sc, {d_row, d_col});
      end
      if ({d_hs, d_vs} !== 2'b00) begin
        errors++; $display("FAIL reset_mid_sync_d scenario=%0d got=%b exp=00", sc, {d_hs, d_vs});
      end
      for (int i = 0; i < 1200; i++) begin
        step();
        exp_v = model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_LAT);
        checks++;
        if (obs_d !== exp_v) begin errors++; $display("FAIL after_reset_d k=%0d got=%h exp=%h", k, obs_d, exp_v); end
        exp_v = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL after_reset_s k=%0d got=%h exp=%h", k, obs_s, exp_v); end
      end
    end
  endtask

  task automatic test_random_resets();
    int n;
    for (int it = 0; it < 4; it++) begin
      mode = $urandom_range(0, 2);
      seed = $urandom;
      do_reset($urandom_range(1, 3));
      n = $urandom_range(200, 1500);
      for (int i = 0; i < n; i++) begin
        step();
        exp_v = model(k, D_HA, D_HF, D_HS, D_HB, D_VA, D_VF, D_VS, D_VB, D_LAT);
        checks++;
        if (obs_d !== exp_v) begin errors++; $display("FAIL rand_d k=%0d got=%h exp=%h", k, obs_d, exp_v); end
        exp_v = model(k, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_LAT);
        checks++;
        if (obs_s !== exp_v) begin errors++; $display("FAIL rand_s k=%0d got=%h exp=%h", k, obs_s, exp_v); end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    k = 0;
    mode = 0;
    seed = 32'h0;
    rst_n = 1'b0;
    {d_red, d_green, d_blue} = '0;
    {s_red, s_green, s_blue} = '0;
    repeat (D_LAT) q_d.push_back(16'($urandom));
    repeat (S_LAT) q_s.push_back(16'($urandom));
    test_reset();
    test_free_run();
    test_line_sync();
    test_vsync();
    test_colour_path();
    test_blanking();
    test_reset_mid();
    test_random_resets();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
